// File: rtl/mcp3204_sequencer.sv
// mcp3204_sequencer: periodic channel-sweep scheduler for the MCP3204 SPI ADC core.
// A prescaled sample tick starts a sweep over the channels enabled in ch_mask.
// Each enabled channel gets one conv_start/conv_done exchange with the ADC core.
// Each result is sent as one tagged AXI-Stream beat.
//
// Ports
//   aclk, resetn      clock, asynchronous active-low reset
//   enable            runs the sample-tick counter (0 holds it at 0)
//   ch_mask[3:0]      channel enables, latched at sweep start
//   clear_err         pulse clearing the sticky overrun/timeout flags
//   conv_start        one-cycle start pulse to the ADC core
//   conv_ch[1:0]      channel under conversion, stable start..done
//   conv_done         one-cycle result strobe from the ADC core
//   conv_data[11:0]   conversion result
//   m_axis_*          result stream: tdata = {2'b00, ch, sample}, tlast on last channel
//   overrun           sticky: tick arrived while a sweep was in progress
//   timeout           sticky: ADC core failed to answer within TIMEOUT_CYCLES
module mcp3204_sequencer #(
  parameter int unsigned PRESCALER_SAMPLE = 1000,
  parameter int unsigned PRESCALER_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES   = 255
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [3:0]  ch_mask,
  input  logic        clear_err,
  output logic        conv_start,
  output logic [1:0]  conv_ch,
  input  logic        conv_done,
  input  logic [11:0] conv_data,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overrun,
  output logic        timeout
);

  localparam int unsigned TimeoutWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [PRESCALER_WIDTH-1:0] TickLast = PRESCALER_WIDTH'(PRESCALER_SAMPLE - 1);
  localparam logic [TimeoutWidth-1:0]    TimeoutLast = TimeoutWidth'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StStart, StConvert, StOutput} state_e;

  state_e                    state_q, state_d;
  logic [PRESCALER_WIDTH-1:0] cnt_q;
  logic                      tick_q;
  logic [3:0]                mask_q, mask_d;
  logic [1:0]                ch_q, ch_d;
  logic [11:0]               data_q, data_d;
  logic [TimeoutWidth-1:0]   to_cnt_q, to_cnt_d;
  logic                      overrun_q, timeout_q;
  logic                      set_to, set_ovr, advance;
  logic [3:0]                above;
  logic [2:0]                first_sel, next_sel;

  // Returns {found, index} of the lowest set bit.
  function automatic logic [2:0] first_set(input logic [3:0] m);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Channels of the latched mask strictly above the current one.
  assign above     = mask_q & (4'b1110 << ch_q);
  assign first_sel = first_set(ch_mask);
  assign next_sel  = first_set(above);

  // Tick is registered so the first one lands PRESCALER_SAMPLE cycles after enable rises.
  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= enable && (cnt_q == TickLast);
      if (!enable || (cnt_q == TickLast)) cnt_q <= '0;
      else                                cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      mask_q    <= '0;
      ch_q      <= '0;
      data_q    <= '0;
      to_cnt_q  <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      ch_q      <= ch_d;
      data_q    <= data_d;
      to_cnt_q  <= to_cnt_d;
      // A new set event wins over a simultaneous clear.
      overrun_q <= set_ovr | (overrun_q & ~clear_err);
      timeout_q <= set_to  | (timeout_q & ~clear_err);
    end
  end

  assign set_ovr = tick_q && (state_q != StIdle);

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    ch_d     = ch_q;
    data_d   = data_q;
    to_cnt_d = to_cnt_q;
    set_to   = 1'b0;
    advance  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (tick_q && (ch_mask != 4'b0000)) begin
          mask_d  = ch_mask;
          ch_d    = first_sel[1:0];
          state_d = StStart;
        end
      end
      StStart: begin
        to_cnt_d = '0;
        state_d  = StConvert;
      end
      StConvert: begin
        if (conv_done) begin
          data_d  = conv_data;
          state_d = StOutput;
        end else if (to_cnt_q == TimeoutLast) begin
          set_to  = 1'b1;
          advance = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      StOutput: begin
        if (m_axis_tready) advance = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (advance) begin
      if (next_sel[2]) begin
        ch_d    = next_sel[1:0];
        state_d = StStart;
      end else begin
        state_d = StIdle;
      end
    end
  end

  assign conv_start    = (state_q == StStart);
  assign conv_ch       = ch_q;
  assign m_axis_tvalid = (state_q == StOutput);
  assign m_axis_tlast  = m_axis_tvalid && (above == 4'b0000);
  assign m_axis_tdata  = {2'b00, ch_q, data_q};
  assign overrun       = overrun_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_mcp3204_sequencer.sv
// tb_mcp3204_sequencer: scoreboard bench for mcp3204_sequencer.
// The driver plans each sweep as a timeline (start cycles, ADC answers, ready stalls, beats)
// from the documented latencies and pushes expectations into queues.
// A negedge monitor pops and compares whatever the DUT presents.
module tb_mcp3204_sequencer;

  localparam int PS = 20;
  localparam int TO = 8;

  logic        aclk = 1'b0;
  logic        resetn = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  ch_mask = 4'h0;
  logic        clear_err = 1'b0;
  logic        conv_start;
  logic [1:0]  conv_ch;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = 12'h000;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic        overrun;
  logic        timeout;

  mcp3204_sequencer #(
    .PRESCALER_SAMPLE(PS),
    .PRESCALER_WIDTH (16),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .aclk         (aclk),
    .resetn       (resetn),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .clear_err    (clear_err),
    .conv_start   (conv_start),
    .conv_ch      (conv_ch),
    .conv_done    (conv_done),
    .conv_data    (conv_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .overrun      (overrun),
    .timeout      (timeout)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int         cyc;
    logic [1:0] ch;
  } start_t;

  typedef struct {
    int          first;
    int          hs;
    logic [15:0] data;
    logic        last;
  } beat_t;

  start_t      exp_start[$];
  beat_t       exp_beat[$];
  logic [11:0] done_plan[int];
  bit          ready_plan[int];
  bit          to_plan[int];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   mon_en = 0;

  // Model state
  int   run_len = 0;
  int   busy_until = 0;
  logic m_ovr = 0, m_ovr_nxt = 0, m_to = 0, m_to_nxt = 0;

  // Stimulus controls
  logic       nx_enable = 0;
  logic [3:0] nx_mask = 4'h0;
  bit         clr_req = 0;
  bit         data_mode = 0;
  bit         w_zero = 0;
  bit         rand_mode = 0;
  int         l_fixed = 0;
  int         w_first = -1;
  logic [3:0] dead_mask = 4'h0;
  bit         reset_next = 0;
  bit         drop_en_next = 0;
  int         drop_en_at = -1;
  int         rst_from = 1;
  int         rst_to = 4;

  function automatic int rand_w();
    if (w_zero) return 0;
    if ($urandom_range(0, 9) < 7) return 0;
    return $urandom_range(1, 6);
  endfunction

  task automatic plan_sweep(input int t, input logic [3:0] m);
    int          s, l, w, v;
    logic [11:0] d;
    logic [3:0]  dead, hi;
    start_t      st;
    beat_t       bt;
    s    = t + 1;
    dead = dead_mask;
    if (rand_mode && ($urandom_range(0, 5) == 0)) dead[$urandom_range(0, 3)] = 1'b1;
    if (reset_next) begin
      rst_from = t + 3;
      rst_to   = t + 5;
    end
    if (drop_en_next) drop_en_at = t + 3;
    for (int ch = 0; ch < 4; ch++) begin
      if (m[ch]) begin
        st.cyc = s;
        st.ch  = 2'(ch);
        exp_start.push_back(st);
        if (dead[ch]) begin
          to_plan[s + TO] = 1;
          s = s + TO + 1;
        end else begin
          l = (l_fixed > 0) ? l_fixed : $urandom_range(1, 4);
          if (reset_next) l = 6;
          d = data_mode ? 12'(12'hA00 + ch) : 12'($urandom);
          done_plan[s + l] = d;
          v = s + l + 1;
          if (w_first >= 0) begin
            w = w_first;
            w_first = -1;
          end else begin
            w = rand_w();
          end
          for (int k = 0; k < w; k++) ready_plan[v + k] = 0;
          ready_plan[v + w] = 1;
          hi = m >> (ch + 1);
          bt.first = v;
          bt.hs    = v + w;
          bt.data  = {2'b00, 2'(ch), d};
          bt.last  = (hi == 4'h0);
          exp_beat.push_back(bt);
          s = v + w + 1;
        end
      end
    end
    busy_until   = s;
    reset_next   = 0;
    drop_en_next = 0;
  endtask

  task automatic step();
    bit tick, ovr_ev;
    @(posedge aclk);
    #1;
    cyc++;
    m_ovr = m_ovr_nxt;
    m_to  = m_to_nxt;
    resetn = !((cyc >= rst_from) && (cyc < rst_to));
    if (cyc == drop_en_at) nx_enable = 0;
    enable    = nx_enable;
    ch_mask   = nx_mask;
    clear_err = clr_req;
    clr_req   = 0;
    conv_done = done_plan.exists(cyc);
    conv_data = done_plan.exists(cyc) ? done_plan[cyc] : 12'($urandom);
    m_axis_tready = ready_plan.exists(cyc) ? ready_plan[cyc] : 1'($urandom_range(0, 1));
    if (!resetn) begin
      exp_start.delete();
      exp_beat.delete();
      ready_plan.delete();
      to_plan.delete();
      run_len = 0;
      busy_until = 0;
      m_ovr = 0;
      m_to = 0;
      m_ovr_nxt = 0;
      m_to_nxt = 0;
    end else begin
      tick   = (run_len >= PS) && ((run_len % PS) == 0);
      ovr_ev = 0;
      if (tick) begin
        if (cyc < busy_until) ovr_ev = 1;
        else if (ch_mask != 4'h0) plan_sweep(cyc, ch_mask);
      end
      m_ovr_nxt = ovr_ev ? 1'b1 : (clear_err ? 1'b0 : m_ovr);
      m_to_nxt  = to_plan.exists(cyc) ? 1'b1 : (clear_err ? 1'b0 : m_to);
      run_len   = enable ? run_len + 1 : 0;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      if (rand_mode) begin
        if ($urandom_range(0, 63) == 0) nx_mask = 4'($urandom);
        if ($urandom_range(0, 149) == 0) clr_req = 1;
        if ($urandom_range(0, 399) == 0) nx_enable = !nx_enable;
      end
      step();
    end
  endtask

  // Monitor
  logic        s_exp, b_exp;
  logic [1:0]  e_ch;
  beat_t       eb;

  always @(negedge aclk) begin
    if (mon_en) begin
      while ((exp_start.size() > 0) && (exp_start[0].cyc < cyc)) begin
        checks++;
        errors++;
        $display("FAIL conv_start_missing: cycle %0d got none, expected start on ch %0d",
                 exp_start[0].cyc, exp_start[0].ch);
        void'(exp_start.pop_front());
      end
      s_exp = (exp_start.size() > 0) && (exp_start[0].cyc == cyc);
      e_ch  = s_exp ? exp_start[0].ch : 2'd0;
      if (conv_start || s_exp) begin
        checks++;
        if ((conv_start !== s_exp) || (s_exp && (conv_ch !== e_ch))) begin
          errors++;
          $display("FAIL conv_start: cycle %0d got start=%0b ch=%0d, expected start=%0b ch=%0d",
                   cyc, conv_start, conv_ch, s_exp, e_ch);
        end
        if (s_exp) void'(exp_start.pop_front());
      end

      b_exp = (exp_beat.size() > 0) && (exp_beat[0].first <= cyc);
      checks++;
      if (m_axis_tvalid !== b_exp) begin
        errors++;
        $display("FAIL tvalid: cycle %0d got %0b, expected %0b", cyc, m_axis_tvalid, b_exp);
      end else if (b_exp) begin
        eb = exp_beat[0];
        checks++;
        if ((m_axis_tdata !== eb.data) || (m_axis_tlast !== eb.last)) begin
          errors++;
          $display("FAIL beat: cycle %0d got tdata=%h tlast=%0b, expected tdata=%h tlast=%0b",
                   cyc, m_axis_tdata, m_axis_tlast, eb.data, eb.last);
        end
      end
      if (b_exp && (cyc >= exp_beat[0].hs)) void'(exp_beat.pop_front());

      checks++;
      if ((overrun !== m_ovr) || (timeout !== m_to)) begin
        errors++;
        $display("FAIL flags: cycle %0d got overrun=%0b timeout=%0b, expected overrun=%0b timeout=%0b",
                 cyc, overrun, timeout, m_ovr, m_to);
      end
    end
  end

  initial begin
    // Reset then full-mask sweeps with fixed ADC answers and no back-pressure
    nx_enable = 1;
    nx_mask   = 4'hF;
    data_mode = 1;
    l_fixed   = 1;
    w_zero    = 1;
    step();
    mon_en = 1;
    run(75);

    // Sparse mask, then empty mask
    data_mode = 0;
    l_fixed   = 0;
    w_zero    = 0;
    nx_mask   = 4'b1010;
    run(60);
    nx_mask = 4'h0;
    run(60);

    // Long back-pressure on the ch0 beat forces an overrun, then clear it
    nx_mask = 4'hF;
    w_first = 50;
    run(110);
    clr_req = 1;
    run(30);

    // ADC never answers on ch2
    dead_mask = 4'b0100;
    run(60);
    dead_mask = 4'h0;
    clr_req = 1;
    run(30);

    // Reset while converting; the late conv_done must be ignored
    reset_next = 1;
    run(70);

    // Enable dropped mid-sweep, then restored
    drop_en_next = 1;
    run(100);
    nx_enable = 1;
    run(60);

    // Randomised traffic
    rand_mode = 1;
    run(2000);
    rand_mode = 0;
    nx_enable = 0;
    run(200);

    while (exp_start.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL start_leftover: got none, expected start at cycle %0d", exp_start[0].cyc);
      void'(exp_start.pop_front());
    end
    while (exp_beat.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL beat_leftover: got none, expected tdata=%h", exp_beat[0].data);
      void'(exp_beat.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
